// File: rtl/pinred_pkg.sv
// Shared type tags, default widths and width helpers for the pin-reduced
// memory deserializer. PINRED_PARITY_EN enables the per-word parity bit.
package pinred_pkg;

  typedef enum logic [1:0] {
    DT_IDLE  = 2'd0,
    DT_ROMA  = 2'd1,
    DT_SRAMA = 2'd2,
    DT_SRAMD = 2'd3
  } dtype_t;

  localparam int ROM_AW_DEF  = 7;
  localparam int SRAM_AW_DEF = 10;
  localparam int DW_DEF      = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Wide enough to hold the parity-bit position (count == width) as well.
  function automatic int cnt_width(input int max_w);
    return $clog2(max_w) + 1;
  endfunction

endpackage

// File: rtl/pinred_shift_chan.sv
// One deserializer channel: MSB-first shift register, bit counter, commit
// and abort handling. With PINRED_PARITY_EN each word carries a trailing
// even-parity bit and a bad word is dropped.
module pinred_shift_chan #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         ser,
  output logic [W-1:0] word,
  output logic         busy,
  output logic         commit,
  output logic         perr
);

`ifdef PINRED_PARITY_EN
  localparam int LAST = W;
`else
  localparam int LAST = W - 1;
`endif

  logic [W-1:0]  shreg;
  logic [W-1:0]  shifted;
  logic [W-1:0]  word_next;
  logic [CW-1:0] cnt;
  logic          last_bit;

  assign shifted  = {shreg[W-2:0], ser};
  assign last_bit = shift_en && (cnt == CW'(LAST));
  assign busy     = (cnt != '0);

`ifdef PINRED_PARITY_EN
  // The data bits are already in shreg when the parity bit arrives.
  logic parity_ok;
  assign parity_ok = ~(^shreg ^ ser);
  assign word_next = shreg;
  assign commit    = last_bit & parity_ok;
  assign perr      = last_bit & ~parity_ok;
`else
  assign word_next = shifted;
  assign commit    = last_bit;
  assign perr      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
      word  <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      if (last_bit) begin
        shreg <= '0;
        cnt   <= '0;
        if (commit) begin
          word <= word_next;
        end
      end else begin
        shreg <= shifted;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pinred_mem_deser.sv
// Receive-side deserializer for the pin-reduced memory interface: three
// shift channels, abort detection and SRAM address/data write pairing.
// Optional per-word parity checking is enabled by PINRED_PARITY_EN.
module pinred_mem_deser
  import pinred_pkg::*;
#(
  parameter int ROM_AW  = ROM_AW_DEF,
  parameter int SRAM_AW = SRAM_AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ser_i,
  input  logic [1:0]         dtype_i,
  output logic [ROM_AW-1:0]  rom_a_o,
  output logic               rom_a_vld_o,
  output logic [SRAM_AW-1:0] sram_a_o,
  output logic [DW-1:0]      sram_d_o,
  output logic               mem_we_n_o,
  output logic               frame_err_o,
  output logic               parity_err_o
);

  localparam int CW = cnt_width(max3(ROM_AW, SRAM_AW, DW));

  dtype_t     dt;
  logic [2:0] sel;
  logic [2:0] busy;
  logic [2:0] clear;
  logic [2:0] commit;
  logic [2:0] perr;
  logic       any_sel;
  logic       a_pend;
  logic       d_pend;
  logic       fire;

  assign dt      = dtype_t'(dtype_i);
  assign sel[0]  = (dt == DT_ROMA);
  assign sel[1]  = (dt == DT_SRAMA);
  assign sel[2]  = (dt == DT_SRAMD);
  assign any_sel = (dt != DT_IDLE);

  // A busy channel is aborted when a different non-idle tag shows up.
  assign clear = {3{any_sel}} & ~sel & busy;
  assign fire  = a_pend & d_pend;

  pinred_shift_chan #(.W(ROM_AW), .CW(CW)) u_rom_chan (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sel[0]),
    .clear    (clear[0]),
    .ser      (ser_i),
    .word     (rom_a_o),
    .busy     (busy[0]),
    .commit   (commit[0]),
    .perr     (perr[0])
  );

  pinred_shift_chan #(.W(SRAM_AW), .CW(CW)) u_sram_a_chan (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sel[1]),
    .clear    (clear[1]),
    .ser      (ser_i),
    .word     (sram_a_o),
    .busy     (busy[1]),
    .commit   (commit[1]),
    .perr     (perr[1])
  );

  pinred_shift_chan #(.W(DW), .CW(CW)) u_sram_d_chan (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sel[2]),
    .clear    (clear[2]),
    .ser      (ser_i),
    .word     (sram_d_o),
    .busy     (busy[2]),
    .commit   (commit[2]),
    .perr     (perr[2])
  );

  // A commit landing on the same edge as the pair clear keeps its flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_a_vld_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      mem_we_n_o   <= 1'b1;
      a_pend       <= 1'b0;
      d_pend       <= 1'b0;
    end else begin
      rom_a_vld_o  <= commit[0];
      frame_err_o  <= |clear;
      parity_err_o <= |perr;
      mem_we_n_o   <= ~fire;
      a_pend       <= commit[1] | (a_pend & ~fire);
      d_pend       <= commit[2] | (d_pend & ~fire);
    end
  end

endmodule

// File: tb/tb_pinred_mem_deser.sv
// Self-checking bench for pinred_mem_deser: table-driven words plus hand
// sequences for abort, gaps, reset mid-word and (PINRED_PARITY_EN) parity.
module tb_pinred_mem_deser;
  import pinred_pkg::*;

  localparam int ROM_AW  = 7;
  localparam int SRAM_AW = 10;
  localparam int DW      = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               ser_i;
  logic [1:0]         dtype_i;
  logic [ROM_AW-1:0]  rom_a_o;
  logic               rom_a_vld_o;
  logic [SRAM_AW-1:0] sram_a_o;
  logic [DW-1:0]      sram_d_o;
  logic               mem_we_n_o;
  logic               frame_err_o;
  logic               parity_err_o;

  always #5 clk = ~clk;

  pinred_mem_deser #(.ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ser_i        (ser_i),
    .dtype_i      (dtype_i),
    .rom_a_o      (rom_a_o),
    .rom_a_vld_o  (rom_a_vld_o),
    .sram_a_o     (sram_a_o),
    .sram_d_o     (sram_d_o),
    .mem_we_n_o   (mem_we_n_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  typedef struct {
    dtype_t      dt;
    logic [15:0] value;
    logic [15:0] exp_reg;
    int          exp_strobes;
  } vec_t;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_seen      = 0;
  int frame_seen   = 0;
  int frame_exp    = 0;
  int perr_seen    = 0;
  int perr_exp     = 0;

  // Scoreboard: expected ROM commits and expected write-strobe pairs.
  logic [ROM_AW-1:0]       rom_q[$];
  logic [SRAM_AW+DW-1:0]   wr_q[$];
  logic [ROM_AW-1:0]       m_rom;
  logic [SRAM_AW-1:0]      m_a;
  logic [DW-1:0]           m_d;
  bit                      m_ap;
  bit                      m_dp;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_unexpected(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic monitor();
    if (rom_a_vld_o) begin
      if (rom_q.size() == 0) report_unexpected("rom_vld_extra", 32'(rom_a_o));
      else check_output("rom_vld_addr", 32'(rom_a_o), 32'(rom_q.pop_front()));
    end
    if (!mem_we_n_o) begin
      we_seen++;
      if (wr_q.size() == 0) report_unexpected("we_extra", 32'({sram_a_o, sram_d_o}));
      else check_output("we_pair", 32'({sram_a_o, sram_d_o}), 32'(wr_q.pop_front()));
    end
    if (frame_err_o)  frame_seen++;
    if (parity_err_o) perr_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset) monitor();
  endtask

  task automatic idle(input int n);
    dtype_i = DT_IDLE;
    ser_i   = 1'b0;
    repeat (n) step();
  endtask

  function automatic int width_of(input dtype_t dt);
    case (dt)
      DT_ROMA:  return ROM_AW;
      DT_SRAMA: return SRAM_AW;
      default:  return DW;
    endcase
  endfunction

  function automatic void model_commit(input dtype_t dt, input logic [15:0] v);
    case (dt)
      DT_ROMA: begin
        m_rom = v[ROM_AW-1:0];
        rom_q.push_back(m_rom);
      end
      DT_SRAMA: begin
        m_a  = v[SRAM_AW-1:0];
        m_ap = 1'b1;
      end
      default: begin
        m_d  = v[DW-1:0];
        m_dp = 1'b1;
      end
    endcase
    if (m_ap && m_dp) begin
      wr_q.push_back({m_a, m_d});
      m_ap = 1'b0;
      m_dp = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_rom = '0;
    m_a   = '0;
    m_d   = '0;
    m_ap  = 1'b0;
    m_dp  = 1'b0;
  endfunction

  // Drives word bits [from, to) counted from the MSB.
  task automatic send_bits(input dtype_t dt, input logic [15:0] v,
                           input int from, input int to);
    int w;
    w = width_of(dt);
    for (int i = from; i < to; i++) begin
      dtype_i = dt;
      ser_i   = v[w-1-i];
      step();
    end
  endtask

  task automatic send_parity(input dtype_t dt, input logic [15:0] v, input bit bad);
`ifdef PINRED_PARITY_EN
    logic [15:0] masked;
    masked  = v & ((16'd1 << width_of(dt)) - 16'd1);
    dtype_i = dt;
    ser_i   = (^masked) ^ bad;
    if (bad) perr_exp++;
    step();
`else
    if (bad) $display("[TB] note: parity not built in for tag %0d value %0h", dt, v);
`endif
  endtask

  task automatic apply_stimulus(input dtype_t dt, input logic [15:0] v, input bit bad_par);
`ifdef PINRED_PARITY_EN
    if (!bad_par) model_commit(dt, v);
`else
    model_commit(dt, v);
`endif
    send_bits(dt, v, 0, width_of(dt));
    send_parity(dt, v, bad_par);
  endtask

  function automatic logic [15:0] reg_of(input dtype_t dt);
    case (dt)
      DT_ROMA:  return 16'(rom_a_o);
      DT_SRAMA: return 16'(sram_a_o);
      default:  return 16'(sram_d_o);
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check_output({tag, "_rom_a"},   32'(rom_a_o), 32'h0);
    check_output({tag, "_rom_vld"}, 32'(rom_a_vld_o), 32'h0);
    check_output({tag, "_sram_a"},  32'(sram_a_o), 32'h0);
    check_output({tag, "_sram_d"},  32'(sram_d_o), 32'h0);
    check_output({tag, "_we_n"},    32'(mem_we_n_o), 32'h1);
    check_output({tag, "_frame"},   32'(frame_err_o), 32'h0);
    check_output({tag, "_perr"},    32'(parity_err_o), 32'h0);
  endtask

  vec_t vecs[10];

  initial begin
    int we_before;
    int frame_before;

    vecs[0] = '{DT_ROMA,  16'h055, 16'h055, 0};
    vecs[1] = '{DT_SRAMA, 16'h3A5, 16'h3A5, 0};
    vecs[2] = '{DT_SRAMD, 16'h0C3, 16'h0C3, 1};
    vecs[3] = '{DT_ROMA,  16'h02A, 16'h02A, 0};
    vecs[4] = '{DT_SRAMD, 16'h001, 16'h001, 0};
    vecs[5] = '{DT_SRAMD, 16'h0FF, 16'h0FF, 0};
    vecs[6] = '{DT_SRAMA, 16'h000, 16'h000, 1};
    vecs[7] = '{DT_SRAMA, 16'h3FF, 16'h3FF, 0};
    vecs[8] = '{DT_ROMA,  16'h07F, 16'h07F, 0};
    vecs[9] = '{DT_SRAMD, 16'h000, 16'h000, 1};

    model_reset();
    reset   = 1'b1;
    dtype_i = DT_IDLE;
    ser_i   = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    idle(1);
    check_reset_state("reset");

    for (int i = 0; i < 10; i++) begin
      we_before = we_seen;
      apply_stimulus(vecs[i].dt, vecs[i].value, 1'b0);
      check_output($sformatf("vec%0d_reg", i), 32'(reg_of(vecs[i].dt)), 32'(vecs[i].exp_reg));
      idle(2);
      check_output($sformatf("vec%0d_strobes", i), we_seen - we_before, vecs[i].exp_strobes);
    end

    // Abort: partial address, then a full data word starting immediately.
    we_before    = we_seen;
    frame_before = frame_seen;
    send_bits(DT_SRAMA, 16'h155, 0, 4);
    frame_exp++;
    apply_stimulus(DT_SRAMD, 16'h05A, 1'b0);
    idle(2);
    check_output("abort_frame", frame_seen - frame_before, 1);
    check_output("abort_sram_a", 32'(sram_a_o), 32'h3FF);
    check_output("abort_sram_d", 32'(sram_d_o), 32'h5A);
    check_output("abort_strobes", we_seen - we_before, 0);

    // Gap: idle cycles inside an address word must not disturb it.
    we_before    = we_seen;
    frame_before = frame_seen;
    send_bits(DT_SRAMA, 16'h2F0, 0, 5);
    idle(3);
    model_commit(DT_SRAMA, 16'h2F0);
    send_bits(DT_SRAMA, 16'h2F0, 5, SRAM_AW);
    send_parity(DT_SRAMA, 16'h2F0, 1'b0);
    check_output("gap_sram_a", 32'(sram_a_o), 32'h2F0);
    idle(2);
    check_output("gap_frame", frame_seen - frame_before, 0);
    check_output("gap_strobes", we_seen - we_before, 1);

    // Reset in the middle of a data word discards the partial bits.
    send_bits(DT_SRAMD, 16'h0AA, 0, 6);
    reset   = 1'b1;
    dtype_i = DT_IDLE;
    step();
    reset = 1'b0;
    model_reset();
    check_reset_state("midreset");
    we_before = we_seen;
    apply_stimulus(DT_SRAMD, 16'h081, 1'b0);
    check_output("midreset_sram_d", 32'(sram_d_o), 32'h81);
    idle(2);
    check_output("midreset_strobes", we_seen - we_before, 0);

`ifdef PINRED_PARITY_EN
    apply_stimulus(DT_SRAMD, 16'h0C3, 1'b1);
    idle(1);
    check_output("parity_bad_sram_d", 32'(sram_d_o), 32'h81);
    apply_stimulus(DT_SRAMD, 16'h0C3, 1'b0);
    check_output("parity_good_sram_d", 32'(sram_d_o), 32'hC3);
    idle(2);
`endif

    check_output("frame_total", frame_seen, frame_exp);
    check_output("perr_total", perr_seen, perr_exp);
    check_output("rom_q_drained", rom_q.size(), 0);
    check_output("wr_q_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pinred_mem_deser.md
Name: pinred_mem_deser

Overview:
- Generic receive-side deserializer for the pin-reduced memory interface of the labeling engine.
- Engine drives a 1-bit serial stream plus a 2-bit type tag per clock. This block rebuilds ROM address, SRAM address and SRAM write data into parallel registers.
- It pairs SRAM address and data words into single-cycle write strobes.
- It is the parametrised successor of the fixed-count bench shifters: widths are parametrised, a per-channel bit counter replaces fixed commit counts, and abort/error detection is added.

Parameters:
- ROM_AW, 7, ROM address width in bits.
- SRAM_AW, 10, SRAM address width in bits.
- DW, 8, SRAM write-data width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ser_i  in  1  serial bit, MSB first.
- dtype_i  in  2  type tag: 0 idle, 1 ROM addr, 2 SRAM addr, 3 SRAM data.
- rom_a_o  out  ROM_AW  last committed ROM address.
- rom_a_vld_o  out  1  one-cycle pulse on ROM address commit.
- sram_a_o  out  SRAM_AW  last committed SRAM address.
- sram_d_o  out  DW  last committed SRAM data.
- mem_we_n_o  out  1  active-low SRAM write strobe, one cycle wide.
- frame_err_o  out  1  one-cycle pulse on aborted word.
- parity_err_o  out  1  one-cycle pulse on parity mismatch; tied 0 without PARITY_EN.

Behaviour:
- Reset: every output register, shift register, bit counter and pending flag cleared to 0. mem_we_n_o resets to 1. A reset mid-word discards the partial bits.
- Shifting: on a cycle with dtype_i=k (k=1..3), channel k shifts left and loads ser_i into the LSB, then increments its counter.
- Commit: when channel k samples its final bit (ROM_AW / SRAM_AW / DW bits):
  - Output register updates at that same edge.
  - Counter returns to 0.
  - rom_a_vld_o pulses for the channel 1 commit.
  - Latency: the word is visible on the clock after its last bit.
- Output registers hold their value until the next commit of the same channel.
- dtype_i=0 is a pause. All counters and partial words hold, so gaps of any length are legal.
- Abort: dtype_i switches to a different non-zero type while another channel has a counter not equal to 0.
  - That channel's counter and partial word are cleared.
  - frame_err_o pulses.
  - The new channel's bit is still sampled normally.
  - Output registers are unchanged.
- At most one channel can be mid-word at any time.
- Write pairing:
  - Flags a_pend and d_pend are set on SRAM address and SRAM data commits respectively.
  - On the cycle after both are set, mem_we_n_o=0 for exactly one cycle, and both flags clear.
  - If a commit lands in the same cycle as the clear, that flag stays set; set wins.
- Re-committing one side before the other only overwrites the register. A second strobe is never issued without a fresh pair.
- Bit counter width is clog2 of the max word width plus 1. No wrap: the counter always resets on commit or abort.

Optional Feature:
- Macro: PINRED_PARITY_EN.
- Defined:
  - Each word is followed by one extra even-parity bit on the same type tag; counters run to width+1.
  - A parity mismatch discards the word: output held, no vld pulse, no pending flag set.
  - parity_err_o pulses in the cycle after the parity bit.
- Undefined: no parity bit is expected and parity_err_o is constant 0.

Decomposition:
- Package pinred_pkg:
  - Dtype code constants DT_IDLE, DT_ROMA, DT_SRAMA, DT_SRAMD.
  - 2-bit dtype typedef.
  - Default width constants.
- Sub-module pinred_shift_chan, parametrised by word width and instantiated 3 times:
  - Contains shift register, counter, commit/abort, and optional parity logic.
- Top-level holds abort detection, write pairing and output strobes.

Test Plan:
- ROM address: dtype=1, bits 1,0,1,0,1,0,1 over 7 cycles -> rom_a_o=7'h55 and rom_a_vld_o=1 one cycle after the 7th bit; mem_we_n_o stays 1.
- Write pair: SRAM addr 10'h3A5 (dtype=2, 10 bits) then data 8'hC3 (dtype=3, 8 bits) -> sram_a_o=3A5, sram_d_o=C3, one cycle later mem_we_n_o=0 for exactly 1 cycle.
- Gap: 5 SRAM-address bits, 3 idle cycles, remaining 5 bits of 10'h2F0 -> sram_a_o=2F0 with no frame_err_o.
- Abort: 4 bits of SRAM address, then dtype=3 -> frame_err_o pulse, sram_a_o keeps its old value, data channel collects from that cycle; a following full 8'h5A commits with no write strobe.
- Reset mid-word: 6 bits of SRAM data, then reset for 1 cycle, then full 8'h81 -> sram_d_o=81, all state clean.
- With PINRED_PARITY_EN: data 8'hC3 plus parity bit 1 (wrong) -> parity_err_o pulse and sram_d_o unchanged. Data 8'hC3 plus parity 0 -> sram_d_o=C3 committed.
